bcd_display_scan: RTL and testbench
===================================

BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 100000: clock cycles per digit time slot; the block SHALL support any value >= 2.
REQ-002 clk  in  1  rising-edge clock; the block SHALL have one clock only.
REQ-003 rst  in  1  reset; it SHALL be synchronous and active-high.
REQ-004 load  in  1  capture strobe for the three BCD inputs; it SHALL be sampled on the clk rising edge.
REQ-005 hundreds  in  4  BCD hundreds digit, from the upstream binary-to-BCD converter.
REQ-006 tens  in  4  BCD tens digit.
REQ-007 ones  in  4  BCD ones digit.
REQ-008 blank_lz  in  1  leading-zero blanking enable, active-high.
REQ-009 an  out  4  digit anodes, active-low; an[0] drives the ones digit.
REQ-010 seg  out  7  segment cathodes {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  out  1  decimal point, active-low; it SHALL be constant 1.

Function
REQ-012 Shadow registers: load=1 SHALL capture hundreds/tens/ones into shadow registers on that edge; load=0 SHALL hold them.
REQ-013 Prescaler: the counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick SHALL be high only in the cycle where the count equals REFRESH_DIV-1.
REQ-014 Digit select: a 2-bit state SHALL step 0 (ones) -> 1 (tens) -> 2 (hundreds) -> 0 on each tick; state 3 SHALL never be entered and, if reached, SHALL force 0 on the next edge.
REQ-015 Anodes: an SHALL be 1110, 1101 or 1011 for select 0, 1 or 2; an[3] SHALL always be 1.
REQ-016 Decoding: for the selected shadow digit, values 0-9 SHALL give standard 7-segment glyphs; values 10-15 SHALL give a dash (0111111).
REQ-017 Blanking: with blank_lz=1, the hundreds slot SHALL show 1111111 when shadow hundreds==0.
REQ-018 With blank_lz=1, the tens slot SHALL show 1111111 when shadow hundreds==0 and shadow tens==0.
REQ-019 The ones slot SHALL never be blanked; blank_lz is combinational and SHALL take effect at the next output register update.
REQ-020 Output timing: an and seg SHALL be registered and SHALL reflect the select state and shadow contents of the previous cycle (1-cycle latency).
REQ-021 load-to-display latency SHALL be 2 cycles when the loaded digit's slot is active.
REQ-022 Simultaneous load and tick SHALL both take effect; the new slot SHALL show the newly loaded value one cycle later.
REQ-023 Non-BCD inputs SHALL be captured unchanged; the dash SHALL be produced only at decode.

Reset
REQ-024 While rst=1, the shadow registers, prescaler and select SHALL be set to 0, an to 1111, seg to 1111111 and dp to 1.
REQ-025 Reset asserted mid-scan SHALL take effect on the next edge, overriding load and tick.
REQ-026 On the first edge after rst deasserts, the outputs SHALL be an=1110 and seg=1000000 ("0").

Structure
REQ-027 A shared package seg7_pkg SHALL hold SEG_BLANK (1111111), SEG_DASH (0111111), the digit glyph constants and the select state encodings.
REQ-028 A combinational sub-module seg7_decode SHALL map a 4-bit value to 7 segments; bcd_display_scan SHALL instantiate it once.

Verification (REFRESH_DIV=4)
REQ-029 Reset: rst=1 for 3 cycles -> an=1111, seg=1111111 throughout; first edge after release -> an=1110, seg=1000000.
REQ-030 Scan: load 2,5,5 -> an sequence 1110, 1101, 1011, 1110 with each value held exactly 4 cycles; seg sequence 0010010, 0010010, 0100100.
REQ-031 Blanking: load 0,0,7 with blank_lz=1 -> seg 1111000, 1111111, 1111111; with blank_lz=0 -> seg 1111000, 1000000, 1000000.
REQ-032 Invalid digit: load hundreds=1, tens=4'hB, ones=0 -> tens slot seg=0111111; hundreds slot seg=1111001.
REQ-033 Coincidence: load 9,9,9 on the same edge as the tick into the ones slot -> ones slot shows 0010000 two cycles after load.
REQ-034 Mid-scan reset: assert rst during the hundreds slot -> next edge an=1111; after release the scan restarts at the ones slot and the shadow registers read 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path: active-low glyphs
// in {g,f,e,d,c,b,a} order and the digit-select state encodings.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef enum logic [1:0] {
        SEL_ONES     = 2'd0,
        SEL_TENS     = 2'd1,
        SEL_HUNDREDS = 2'd2,
        SEL_INVALID  = 2'd3
    } sel_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes
// render as a dash so upstream conversion faults stay visible.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (value)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Three-digit multiplexed 7-segment driver: shadows the BCD digits,
// scans ones/tens/hundreds at a prescaled rate, blanks leading zeros.
module bcd_display_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_p0;
    logic             tick;
    logic [3:0]       hund_p0;
    logic [3:0]       tens_p0;
    logic [3:0]       ones_p0;
    sel_e             sel_p0;
    sel_e             sel_next;
    logic [3:0]       digit;
    logic             blank;
    logic [6:0]       glyph;
    logic [3:0]       an_next;
    logic [3:0]       an_p1;
    logic [6:0]       seg_p1;

    // Stage p0: shadow digits, prescaler and select state
    always_ff @(posedge clk) begin
        if (rst) begin
            hund_p0 <= 4'd0;
            tens_p0 <= 4'd0;
            ones_p0 <= 4'd0;
        end else if (load) begin
            hund_p0 <= hundreds;
            tens_p0 <= tens;
            ones_p0 <= ones;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            cnt_p0 <= '0;
        end else begin
            cnt_p0 <= cnt_p0 + CNT_W'(1);
        end
    end

    assign tick = (cnt_p0 == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_p0 <= SEL_ONES;
        end else begin
            sel_p0 <= sel_next;
        end
    end

    always_comb begin
        sel_next = sel_p0;
        case (sel_p0)
            SEL_ONES:     if (tick) sel_next = SEL_TENS;
            SEL_TENS:     if (tick) sel_next = SEL_HUNDREDS;
            SEL_HUNDREDS: if (tick) sel_next = SEL_ONES;
            default:      sel_next = SEL_ONES;
        endcase
    end

    // The unreachable select code keeps the display dark for its one cycle
    always_comb begin
        an_next = AN_OFF;
        digit   = ones_p0;
        blank   = 1'b0;
        case (sel_p0)
            SEL_ONES: begin
                an_next = 4'b1110;
            end
            SEL_TENS: begin
                an_next = 4'b1101;
                digit   = tens_p0;
                blank   = blank_lz && (hund_p0 == 4'd0) && (tens_p0 == 4'd0);
            end
            SEL_HUNDREDS: begin
                an_next = 4'b1011;
                digit   = hund_p0;
                blank   = blank_lz && (hund_p0 == 4'd0);
            end
            default: begin
                an_next = AN_OFF;
                blank   = 1'b1;
            end
        endcase
    end

    seg7_decode u_decode (
        .value (digit),
        .seg   (glyph)
    );

    // Stage p1: registered anode and segment drive
    always_ff @(posedge clk) begin
        if (rst) begin
            an_p1  <= AN_OFF;
            seg_p1 <= SEG_BLANK;
        end else begin
            an_p1  <= an_next;
            seg_p1 <= blank ? SEG_BLANK : glyph;
        end
    end

    assign an  = an_p1;
    assign seg = seg_p1;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan with REFRESH_DIV=4: directed scenarios then
// random traffic, all compared against a cycle-count based display model.
module tb_bcd_display_scan;

    localparam int DIV    = 4;
    localparam int PERIOD = 3 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       blank_lz;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks   = 0;
    int failures = 0;

    // Reference state: shadow digits and cycles elapsed since reset
    int         m_t = 0;
    logic [3:0] m_h = 4'd0;
    logic [3:0] m_te = 4'd0;
    logic [3:0] m_o = 4'd0;

    bcd_display_scan #(.REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] exp_glyph(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: predict outputs from pre-edge state, advance the model, compare
    task automatic step(input string tag);
        int         slot;
        logic [3:0] d;
        logic       bl;
        logic [3:0] ea;
        logic [6:0] es;
        if (rst) begin
            ea = 4'b1111;
            es = 7'b1111111;
        end else begin
            slot = (m_t / DIV) % 3;
            d    = (slot == 0) ? m_o : (slot == 1) ? m_te : m_h;
            bl   = blank_lz && ((slot == 2 && m_h == 4'd0) ||
                                (slot == 1 && m_h == 4'd0 && m_te == 4'd0));
            ea   = ~(4'b0001 << slot);
            es   = bl ? 7'b1111111 : exp_glyph(d);
        end
        @(posedge clk);
        if (rst) begin
            m_t  = 0;
            m_h  = 4'd0;
            m_te = 4'd0;
            m_o  = 4'd0;
        end else begin
            if (load) begin
                m_h  = hundreds;
                m_te = tens;
                m_o  = ones;
            end
            m_t++;
        end
        #1;
        chk({tag, "_an"}, {3'b000, an}, {3'b000, ea});
        chk({tag, "_seg"}, seg, es);
        chk({tag, "_dp"}, {6'd0, dp}, 7'd1);
    endtask

    task automatic run_to_phase(input int p);
        int n = 0;
        while ((m_t % PERIOD) != p && n < 2 * PERIOD) begin
            step("idle");
            n++;
        end
        checks++;
        assert ((m_t % PERIOD) == p)
        else begin
            failures++;
            $error("FAIL align observed=%0d expected=%0d", m_t % PERIOD, p);
        end
    endtask

    task automatic load_digits(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        hundreds = h;
        tens     = t;
        ones     = o;
        load     = 1'b1;
        step("load");
        load     = 1'b0;
    endtask

    // Walk one full scan and pin each slot's segments to literal values
    task automatic check_slots(input string tag, input logic [6:0] e0,
                               input logic [6:0] e1, input logic [6:0] e2);
        run_to_phase(0);
        step(tag);
        chk({tag, "_ones_an"}, {3'b000, an}, 7'b0001110);
        chk({tag, "_ones"}, seg, e0);
        repeat (DIV - 1) step(tag);
        step(tag);
        chk({tag, "_tens_an"}, {3'b000, an}, 7'b0001101);
        chk({tag, "_tens"}, seg, e1);
        repeat (DIV - 1) step(tag);
        step(tag);
        chk({tag, "_hund_an"}, {3'b000, an}, 7'b0001011);
        chk({tag, "_hund"}, seg, e2);
        repeat (DIV - 1) step(tag);
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        hundreds = 4'd0;
        tens     = 4'd0;
        ones     = 4'd0;
        blank_lz = 1'b0;

        repeat (3) step("reset");
        rst = 1'b0;
        step("release");
        chk("release_an", {3'b000, an}, 7'b0001110);
        chk("release_seg", seg, 7'b1000000);

        load_digits(4'd2, 4'd5, 4'd5);
        check_slots("scan", 7'b0010010, 7'b0010010, 7'b0100100);

        blank_lz = 1'b1;
        load_digits(4'd0, 4'd0, 4'd7);
        check_slots("blank_on", 7'b1111000, 7'b1111111, 7'b1111111);
        blank_lz = 1'b0;
        check_slots("blank_off", 7'b1111000, 7'b1000000, 7'b1000000);

        load_digits(4'd1, 4'hB, 4'd0);
        check_slots("invalid", 7'b1000000, 7'b0111111, 7'b1111001);

        run_to_phase(PERIOD - 1);
        load_digits(4'd9, 4'd9, 4'd9);
        step("coinc");
        chk("coinc_an", {3'b000, an}, 7'b0001110);
        chk("coinc_seg", seg, 7'b0010000);

        run_to_phase(2 * DIV + 1);
        rst = 1'b1;
        step("midrst");
        chk("midrst_an", {3'b000, an}, 7'b0001111);
        rst = 1'b0;
        step("restart");
        chk("restart_an", {3'b000, an}, 7'b0001110);
        chk("restart_seg", seg, 7'b1000000);
        check_slots("cleared", 7'b1000000, 7'b1000000, 7'b1000000);

        repeat (600) begin
            rst      = ($urandom_range(0, 59) == 0);
            load     = ($urandom_range(0, 3) == 0);
            hundreds = 4'($urandom_range(0, 15));
            tens     = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            ones     = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 3) == 0) hundreds = 4'd0;
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
